// File: rtl/line_rr_arbiter.sv
// Line-granular round-robin arbiter: NumSrc framed sources onto one stream, beats tagged with source id.
// Latency 1 (OutputReg=1, skid-buffered) or 0; stalls only the granted source under backpressure.
module line_rr_arbiter #(
  parameter int unsigned Width     = 64,
  parameter int unsigned NumSrc    = 4,
  parameter bit          OutputReg = 1'b1,
  localparam int unsigned IdW      = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumSrc-1:0]                  s_valid_i,
  output logic [NumSrc-1:0]                  s_ready_o,
  input  logic [NumSrc-1:0]                  s_sof_i,
  input  logic [NumSrc-1:0]                  s_eol_i,
  input  logic [0:NumSrc-1][Width-1:0]       s_data_i,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic                               m_sof_o,
  output logic                               m_eol_o,
  output logic [IdW-1:0]                     m_id_o,
  output logic [Width-1:0]                   m_data_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [IdW-1:0]   id;
    logic [Width-1:0] data;
  } beat_t;

  state_e         state_q;
  logic [IdW-1:0] ptr_q, grant_q;
  logic [IdW-1:0] pick, idx;
  logic           found;
  logic           int_vld, int_rdy;
  beat_t          in_beat;

  // Search starts at ptr and wraps, so the source after the last winner has priority.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < int'(NumSrc); k++) begin
      if (!found && s_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == IdW'(NumSrc - 1)) ? '0 : idx + IdW'(1);
    end
  end

  always_comb begin
    s_ready_o = '0;
    int_vld   = 1'b0;
    in_beat   = '0;
    if (state_q == LOCKED) begin
      s_ready_o[grant_q] = int_rdy;
      int_vld            = s_valid_i[grant_q];
      in_beat.sof        = s_sof_i[grant_q];
      in_beat.eol        = s_eol_i[grant_q];
      in_beat.id         = grant_q;
      in_beat.data       = s_data_i[grant_q];
    end
  end

  // The new grant is only decided in IDLE, which gives the one-cycle bubble between lines.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= pick;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (int_vld && int_rdy && s_eol_i[grant_q]) begin
            ptr_q   <= (grant_q == IdW'(NumSrc - 1)) ? '0 : grant_q + IdW'(1);
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  if (OutputReg) begin : g_reg
    beat_t main_q, skid_q;
    logic  main_vld_q, skid_vld_q;

    // Ready comes from the skid flag alone, keeping m_ready_i off the source ready path.
    assign int_rdy = ~skid_vld_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        main_q     <= '0;
        skid_q     <= '0;
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
      end else if (!main_vld_q || m_ready_i) begin
        if (skid_vld_q) begin
          main_q     <= skid_q;
          main_vld_q <= 1'b1;
          skid_vld_q <= 1'b0;
        end else begin
          main_q     <= in_beat;
          main_vld_q <= int_vld;
        end
      end else if (int_vld && int_rdy) begin
        skid_q     <= in_beat;
        skid_vld_q <= 1'b1;
      end
    end

    assign m_valid_o = main_vld_q;
    assign m_sof_o   = main_q.sof;
    assign m_eol_o   = main_q.eol;
    assign m_id_o    = main_q.id;
    assign m_data_o  = main_q.data;
  end else begin : g_comb
    assign int_rdy   = m_ready_i;
    assign m_valid_o = int_vld;
    assign m_sof_o   = in_beat.sof;
    assign m_eol_o   = in_beat.eol;
    assign m_id_o    = in_beat.id;
    assign m_data_o  = in_beat.data;
  end

endmodule
